onehot_sel_tracker: RTL and testbench
=====================================

# onehot_sel_tracker

Downstream consumer of the registered 4-bit one-hot selector produced by the upstream value-select stage (codes 4'h0, 4'h1, 4'h2, 4'h4, 4'h8). It watches the selector every cycle, measures how long each code is held, and emits one event record per code change (previous code, new code, dwell count) through a valid/ready output buffer. Multi-hot codes are rejected and flagged. It sits between the selector register and the monitoring/logging logic.

## Interface
Parameters:
- CNT_W, 8: dwell counter width; saturates at 2^CNT_W-1.
- FIFO_DEPTH, 4: event buffer depth; power of two, ≥2.

Ports:
- i_clk  in  1  sole clock, rising edge.
- i_reset_n  in  1  synchronous, active-low reset.
- i_code  in  4  selector from upstream; legal = zero or exactly one bit set.
- o_valid  out  1  event buffer non-empty.
- i_ready  in  1  consumer accepts head event.
- o_prev  out  4  head event: code before the change.
- o_next  out  4  head event: code after the change.
- o_dwell  out  CNT_W  head event: cycles o_prev was held.
- o_illegal  out  1  sticky: a multi-hot i_code was sampled.
- o_overflow  out  1  sticky: an event was dropped because the buffer was full.

## Operation
- Internal state: cur_code (4b), dwell (CNT_W), event FIFO, two sticky flags.
- Each rising edge, with i_reset_n high:
  - i_code multi-hot: o_illegal <= 1; i_code ignored; cur_code unchanged; dwell increments (saturating).
  - i_code legal and == cur_code: dwell <= dwell+1, saturating at all-ones (no wrap).
  - i_code legal and != cur_code: push {cur_code, i_code, dwell}; cur_code <= i_code; dwell <= 0.
- Pop when o_valid && i_ready.
- Full FIFO, push without pop: event dropped, o_overflow <= 1; cur_code and dwell still update as for a push.
- Full FIFO, push and pop in the same cycle: both occur, no drop, occupancy unchanged.
- Empty FIFO, push and pop in the same cycle: impossible (o_valid is low). The new event appears the next cycle.
- o_prev, o_next and o_dwell show the FIFO head. They read all-zero when empty.
- Sticky flags clear only on reset.

## Timing
- Reset (i_reset_n low at an edge): o_valid=0, o_prev=o_next=0, o_dwell=0, o_illegal=0, o_overflow=0, cur_code=0, dwell=0, FIFO flushed. Reset mid-operation discards all pending events.
- Latency: a change sampled at edge N gives o_valid=1 after edge N. The record is visible in cycle N+1.
- Dwell counts edges since the last change. After reset, i_code=0 for k edges and then a change gives dwell=k.
- Head data are stable while o_valid && !i_ready.
- No combinational path from i_code or i_ready to any output.

## Configuration
- ONEHOT_SEL_TRACKER_ASSERT_EN defined: embedded immediate assertions are compiled in.
  - cur_code is always legal one-hot-or-zero.
  - o_next != o_prev whenever o_valid is high.
  - Occupancy never exceeds FIFO_DEPTH.
  - Head data are stable under backpressure.
- Undefined: no assertions. Functional behaviour is identical in both builds.

## Structure
- Package onehot_sel_pkg contains:
  - CODE_W = 4
  - legal code constants
  - typedef for the event record struct {prev, next, dwell}
  - function is_legal_code (popcount ≤ 1)
- Sub-module onehot_sel_fifo: synchronous FIFO of event records.
  - Parameterised by FIFO_DEPTH and record width.
  - Exposes full, empty, push, pop and head.
  - Resets synchronously on i_reset_n.
- Top-level logic: change detection, dwell counter, sticky flags.

## Test plan
- Reset, i_code=0 for 3 cycles, then 4'h2 held, i_ready=1 → one event prev=0, next=2, dwell=3; o_valid high exactly 1 cycle.
- Sequence 4'h1 → 4'h4 → 4'h8, each held 2 cycles, with i_ready=0 → 3 events are buffered and drain in order once i_ready=1; dwell values are as computed from the hold lengths.
- i_code=4'h3 for one cycle between two 4'h2 cycles → o_illegal=1, no event, dwell continues counting.
- FIFO_DEPTH=4, i_ready=0, 5 changes → 4 events held, o_overflow=1, 5th event lost. Then a change in the same cycle as a pop while full → no further drop.
- CNT_W=4, i_code held 20 cycles, then a change → dwell=15.
- Assert i_reset_n=0 with 2 events pending → o_valid=0 and all flags clear on the next cycle; the post-reset first change reports prev=0.

Source files
------------

// File: rtl/onehot_sel_pkg.sv
`default_nettype none
// ============================================================================
// onehot_sel_pkg : shared types and helpers for the one-hot selector tracker
// Revision 1.0
// ============================================================================
package onehot_sel_pkg;

    localparam int CODE_W    = 4;
    // Widest dwell field an event record can carry; CNT_W must not exceed it.
    localparam int MAX_CNT_W = 16;

    localparam logic [CODE_W-1:0] CODE_NONE = 4'h0;
    localparam logic [CODE_W-1:0] CODE_SEL0 = 4'h1;
    localparam logic [CODE_W-1:0] CODE_SEL1 = 4'h2;
    localparam logic [CODE_W-1:0] CODE_SEL2 = 4'h4;
    localparam logic [CODE_W-1:0] CODE_SEL3 = 4'h8;

    typedef struct packed {
        logic [CODE_W-1:0]    prev;
        logic [CODE_W-1:0]    next;
        logic [MAX_CNT_W-1:0] dwell;
    } evt_rec_t;

    function automatic logic is_legal_code(input logic [CODE_W-1:0] code);
        return (code & (code - CODE_W'(1))) == '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/onehot_sel_fifo.sv
`default_nettype none
// ============================================================================
// onehot_sel_fifo : synchronous FIFO of packed event records, zero head when empty
// Revision 1.0
// ============================================================================
module onehot_sel_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int REC_W      = 16
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [REC_W-1:0] i_data,
    output logic [REC_W-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [REC_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (count_q == '0);
    assign o_full    = (count_q == CNT_W'(FIFO_DEPTH));
    assign w_do_pop  = i_pop && !o_empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_head    = o_empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (w_do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (w_do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        case ({w_do_push, w_do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

`ifdef ONEHOT_SEL_TRACKER_ASSERT_EN
    always_ff @(posedge i_clk) begin
        if (i_reset_n) begin
            assert (count_q <= CNT_W'(FIFO_DEPTH));
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/onehot_sel_tracker.sv
`default_nettype none
// ============================================================================
// onehot_sel_tracker : logs one-hot selector changes with dwell time into a FIFO
// Optional checks: define ONEHOT_SEL_TRACKER_ASSERT_EN.  Revision 1.0
// ============================================================================
module onehot_sel_tracker
    import onehot_sel_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic [3:0]        i_code,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [3:0]        o_prev,
    output logic [3:0]        o_next,
    output logic [CNT_W-1:0]  o_dwell,
    output logic              o_illegal,
    output logic              o_overflow
);

    localparam int REC_W = 2*CODE_W + CNT_W;

    logic [CODE_W-1:0] cur_code_q, cur_code_d;
    logic [CNT_W-1:0]  dwell_q, dwell_d;
    logic              illegal_q, illegal_d;
    logic              overflow_q, overflow_d;

    logic              w_legal;
    logic              w_change;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    evt_rec_t          w_push_rec;
    logic [REC_W-1:0]  w_push_data;
    logic [REC_W-1:0]  w_head_data;

    assign w_legal  = is_legal_code(i_code);
    assign w_change = w_legal && (i_code != cur_code_q);
    assign w_pop    = !w_empty && i_ready;

    always_comb begin
        w_push_rec       = '0;
        w_push_rec.prev  = cur_code_q;
        w_push_rec.next  = i_code;
        w_push_rec.dwell = MAX_CNT_W'(dwell_q);
    end

    assign w_push_data = {w_push_rec.prev, w_push_rec.next, w_push_rec.dwell[CNT_W-1:0]};

    always_comb begin
        cur_code_d = cur_code_q;
        dwell_d    = dwell_q;
        illegal_d  = illegal_q || !w_legal;
        // A change is dropped only when the FIFO is full and nothing leaves this cycle.
        overflow_d = overflow_q || (w_change && w_full && !w_pop);
        if (w_change) begin
            cur_code_d = i_code;
            dwell_d    = '0;
        end else if (dwell_q != '1) begin
            dwell_d = dwell_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            cur_code_q <= '0;
            dwell_q    <= '0;
            illegal_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            cur_code_q <= cur_code_d;
            dwell_q    <= dwell_d;
            illegal_q  <= illegal_d;
            overflow_q <= overflow_d;
        end
    end

    onehot_sel_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .REC_W      (REC_W)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_push    (w_change),
        .i_pop     (w_pop),
        .i_data    (w_push_data),
        .o_head    (w_head_data),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    assign o_valid    = !w_empty;
    assign o_prev     = w_head_data[REC_W-1 -: CODE_W];
    assign o_next     = w_head_data[CNT_W +: CODE_W];
    assign o_dwell    = w_head_data[CNT_W-1:0];
    assign o_illegal  = illegal_q;
    assign o_overflow = overflow_q;

`ifdef ONEHOT_SEL_TRACKER_ASSERT_EN
    logic             stall_q;
    logic [REC_W-1:0] stall_head_q;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            stall_q      <= 1'b0;
            stall_head_q <= '0;
        end else begin
            stall_q      <= o_valid && !i_ready;
            stall_head_q <= w_head_data;
            assert (is_legal_code(cur_code_q));
            assert (!o_valid || (o_next != o_prev));
            assert (!stall_q || (w_head_data == stall_head_q));
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_onehot_sel_tracker.sv
`default_nettype none
// ============================================================================
// tb_onehot_sel_tracker : directed bench, CNT_W=4 / FIFO_DEPTH=4
// Revision 1.0
// ============================================================================
module tb_onehot_sel_tracker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] code;
    logic       ready;
    logic       valid;
    logic [3:0] prev;
    logic [3:0] next;
    logic [3:0] dwell;
    logic       illegal;
    logic       overflow;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    onehot_sel_tracker #(
        .CNT_W      (4),
        .FIFO_DEPTH (4)
    ) dut (
        .i_clk      (clk),
        .i_reset_n  (rst_n),
        .i_code     (code),
        .o_valid    (valid),
        .i_ready    (ready),
        .o_prev     (prev),
        .o_next     (next),
        .o_dwell    (dwell),
        .o_illegal  (illegal),
        .o_overflow (overflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_head(input string tag, input logic [3:0] p, input logic [3:0] n,
                            input logic [3:0] d);
        chk({tag, ".valid"}, 32'(valid), 32'd1);
        chk({tag, ".prev"},  32'(prev),  32'(p));
        chk({tag, ".next"},  32'(next),  32'(n));
        chk({tag, ".dwell"}, 32'(dwell), 32'(d));
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, ".valid"},    32'(valid),    32'd0);
        chk({tag, ".prev"},     32'(prev),     32'd0);
        chk({tag, ".next"},     32'(next),     32'd0);
        chk({tag, ".dwell"},    32'(dwell),    32'd0);
        chk({tag, ".illegal"},  32'(illegal),  32'd0);
        chk({tag, ".overflow"}, 32'(overflow), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        code  = 4'h0;
        ready = 1'b0;
        tick();
        tick();
        chk_cleared("reset");

        // Three idle edges after reset, then a change to 4'h2.
        rst_n = 1'b1;
        ready = 1'b1;
        tick();
        tick();
        tick();
        chk("idle.valid", 32'(valid), 32'd0);
        code = 4'h2;
        tick();
        chk_head("first", 4'h0, 4'h2, 4'd3);
        tick();
        chk("first.one_cycle", 32'(valid), 32'd0);

        // Multi-hot sample between two 4'h2 samples: flagged, no event, dwell keeps counting.
        code = 4'h3;
        tick();
        chk("illegal.flag", 32'(illegal), 32'd1);
        chk("illegal.noevt", 32'(valid), 32'd0);
        code = 4'h2;
        tick();
        chk("illegal.noevt2", 32'(valid), 32'd0);
        code = 4'h8;
        tick();
        chk_head("illegal_gap", 4'h2, 4'h8, 4'd3);
        tick();

        // Three changes buffered under backpressure, then drained in order.
        ready = 1'b0;
        code  = 4'h1;
        tick();
        tick();
        code = 4'h4;
        tick();
        tick();
        code = 4'h8;
        tick();
        tick();
        chk_head("order0", 4'h8, 4'h1, 4'd1);
        tick();
        chk_head("order_stall", 4'h8, 4'h1, 4'd1);
        ready = 1'b1;
        tick();
        chk_head("order1", 4'h1, 4'h4, 4'd1);
        tick();
        chk_head("order2", 4'h4, 4'h8, 4'd1);
        tick();
        chk("order.empty", 32'(valid), 32'd0);

        // Fill the FIFO, drop a fifth change, then push while popping at full.
        ready = 1'b0;
        code  = 4'h1;
        tick();
        code = 4'h2;
        tick();
        code = 4'h4;
        tick();
        code = 4'h8;
        tick();
        chk("full.no_ovf", 32'(overflow), 32'd0);
        code = 4'h1;
        tick();
        chk("drop.ovf", 32'(overflow), 32'd1);
        chk_head("drop_head", 4'h8, 4'h1, 4'd5);
        ready = 1'b1;
        code  = 4'h2;
        tick();
        chk_head("pushpop_head", 4'h1, 4'h2, 4'd0);
        chk("pushpop.ovf_sticky", 32'(overflow), 32'd1);
        tick();
        chk_head("drain1", 4'h2, 4'h4, 4'd0);
        tick();
        chk_head("drain2", 4'h4, 4'h8, 4'd0);
        tick();
        chk_head("pushpop_kept", 4'h1, 4'h2, 4'd0);
        tick();
        chk("drain.empty", 32'(valid), 32'd0);

        // Hold 4'h2 well past 15 edges: dwell saturates.
        repeat (20) tick();
        code = 4'h4;
        tick();
        chk_head("saturate", 4'h2, 4'h4, 4'd15);

        // Reset with events pending discards them and clears the sticky flags.
        ready = 1'b0;
        code  = 4'h1;
        tick();
        code = 4'h2;
        tick();
        chk_head("pending", 4'h2, 4'h4, 4'd15);
        chk("pending.illegal", 32'(illegal), 32'd1);
        rst_n = 1'b0;
        tick();
        chk_cleared("midreset");
        rst_n = 1'b1;
        code  = 4'h0;
        tick();
        code = 4'h4;
        tick();
        chk_head("post_reset", 4'h0, 4'h4, 4'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
